decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decoder_pkg.sv | 38 +++
 rtl/decode_comb.sv | 95 +++++++++
 rtl/decode_stage.sv | 131 +++++++++++++
 tb/tb_decode_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared decoder definitions: opcode map, field positions,
// write-source mux encoding and skip FSM states.
package decoder_pkg;

    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_OR   = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_NOT  = 5'd6;
    localparam logic [4:0] OP_SHL  = 5'd7;
    localparam logic [4:0] OP_SHR  = 5'd8;
    localparam logic [4:0] OP_VAL  = 5'd9;
    localparam logic [4:0] OP_GOTO = 5'd11;
    localparam logic [4:0] OP_IFZ  = 5'd12;
    localparam logic [4:0] OP_IFNZ = 5'd13;
    localparam logic [4:0] OP_IFEQ = 5'd14;
    localparam logic [4:0] OP_IFST = 5'd15;
    localparam logic [4:0] OP_IFGT = 5'd16;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 11;
    localparam int OP1_HI = 9;
    localparam int OP2_HI = 4;
    localparam int LIT_HI = 7;

    localparam int ST_Z  = 0;
    localparam int ST_LT = 1;
    localparam int ST_GT = 2;

    localparam logic SEL_ALU     = 1'b1;
    localparam logic SEL_DECODER = 1'b0;

    localparam logic RUN  = 1'b0;
    localparam logic SKIP = 1'b1;

endpackage

// File: rtl/decode_comb.sv
// Combinational opcode decode: register selects/enables,
// PC load, write-source mux and IF condition evaluation.
module decode_comb
    import decoder_pkg::*;
#(
    parameter int SEL_WIDTH   = 2,
    parameter int STATUS_BITS = 3
) (
    input  logic [4:0]             opcode,
    input  logic [SEL_WIDTH-1:0]   op1,
    input  logic [SEL_WIDTH-1:0]   op2,
    input  logic [STATUS_BITS-1:0] status,
    output logic [SEL_WIDTH-1:0]   rd_sel1,
    output logic [SEL_WIDTH-1:0]   rd_sel2,
    output logic [SEL_WIDTH-1:0]   wr_sel,
    output logic                   rd_en1,
    output logic                   rd_en2,
    output logic                   wr_en,
    output logic                   cnt_wr_en,
    output logic                   sel_alu,
    output logic                   is_if,
    output logic                   cond_true,
    output logic                   illegal
);

    logic is_alu2;
    logic is_shift;
    logic is_cond;

    always_comb begin
        is_alu2  = opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
        is_shift = opcode inside {OP_SHL, OP_SHR};
        is_cond  = opcode inside {OP_IFZ, OP_IFNZ, OP_IFEQ, OP_IFST, OP_IFGT};
    end

    always_comb begin
        rd_sel1   = '0;
        rd_sel2   = '0;
        wr_sel    = '0;
        rd_en1    = 1'b0;
        rd_en2    = 1'b0;
        wr_en     = 1'b0;
        cnt_wr_en = 1'b0;
        sel_alu   = SEL_DECODER;
        is_if     = 1'b0;
        cond_true = 1'b0;
        illegal   = 1'b0;
        unique case (1'b1)
            is_alu2: begin
                rd_sel1 = op1;
                rd_sel2 = op2;
                wr_sel  = op1;
                rd_en1  = 1'b1;
                rd_en2  = 1'b1;
                wr_en   = 1'b1;
                sel_alu = SEL_ALU;
            end
            (opcode == OP_NOT): begin
                rd_sel2 = op2;
                wr_sel  = op1;
                rd_en2  = 1'b1;
                wr_en   = 1'b1;
                sel_alu = SEL_ALU;
            end
            is_shift: begin
                rd_sel1 = op1;
                wr_sel  = op1;
                rd_en1  = 1'b1;
                wr_en   = 1'b1;
                sel_alu = SEL_ALU;
            end
            (opcode == OP_VAL): begin
                wr_sel = op1;
                wr_en  = 1'b1;
            end
            (opcode == OP_GOTO): begin
                cnt_wr_en = 1'b1;
            end
            is_cond: begin
                is_if = 1'b1;
                case (opcode)
                    OP_IFZ:  cond_true = status[ST_Z];
                    OP_IFNZ: cond_true = !status[ST_Z];
                    OP_IFEQ: cond_true = status[ST_Z];
                    OP_IFST: cond_true = status[ST_LT];
                    default: cond_true = status[ST_GT];
                endcase
            end
            default: begin
                illegal = (opcode != OP_NOP);
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with stall handshake and a one-shot
// skip FSM that squashes the instruction following a false IF.
module decode_stage
    import decoder_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int SEL_WIDTH     = 2,
    parameter int PROGRAM_WIDTH = 16,
    parameter int STATUS_BITS   = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PROGRAM_WIDTH-1:0] instr,
    input  logic                     instr_valid,
    input  logic                     stall,
    input  logic [STATUS_BITS-1:0]   status,
    output logic [4:0]               opcode_q,
    output logic [7:0]               param_q,
    output logic [DATA_WIDTH-1:0]    literal_adr,
    output logic [SEL_WIDTH-1:0]     rd_sel1,
    output logic [SEL_WIDTH-1:0]     rd_sel2,
    output logic [SEL_WIDTH-1:0]     wr_sel,
    output logic                     rd_en1,
    output logic                     rd_en2,
    output logic                     wr_en,
    output logic                     cnt_wr_en,
    output logic                     sel_reg_in_alu_decoder,
    output logic                     out_valid,
    output logic                     skip_pending,
    output logic                     illegal_op
);

    logic [4:0]           d_opcode;
    logic [7:0]           d_lit;
    logic [SEL_WIDTH-1:0] d_rd_sel1;
    logic [SEL_WIDTH-1:0] d_rd_sel2;
    logic [SEL_WIDTH-1:0] d_wr_sel;
    logic                 d_rd_en1;
    logic                 d_rd_en2;
    logic                 d_wr_en;
    logic                 d_cnt_wr_en;
    logic                 d_sel_alu;
    logic                 d_is_if;
    logic                 d_cond_true;
    logic                 d_illegal;
    logic                 state;
    logic                 unused_instr;

    assign d_opcode     = instr[OPC_HI:OPC_LO];
    assign d_lit        = instr[LIT_HI:0];
    assign unused_instr = ^instr;
    assign skip_pending = (state == SKIP);

    decode_comb #(
        .SEL_WIDTH  (SEL_WIDTH),
        .STATUS_BITS(STATUS_BITS)
    ) u_comb (
        .opcode   (d_opcode),
        .op1      (instr[OP1_HI -: SEL_WIDTH]),
        .op2      (instr[OP2_HI -: SEL_WIDTH]),
        .status   (status),
        .rd_sel1  (d_rd_sel1),
        .rd_sel2  (d_rd_sel2),
        .wr_sel   (d_wr_sel),
        .rd_en1   (d_rd_en1),
        .rd_en2   (d_rd_en2),
        .wr_en    (d_wr_en),
        .cnt_wr_en(d_cnt_wr_en),
        .sel_alu  (d_sel_alu),
        .is_if    (d_is_if),
        .cond_true(d_cond_true),
        .illegal  (d_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            opcode_q               <= '0;
            param_q                <= '0;
            literal_adr            <= '0;
            rd_sel1                <= '0;
            rd_sel2                <= '0;
            wr_sel                 <= '0;
            rd_en1                 <= 1'b0;
            rd_en2                 <= 1'b0;
            wr_en                  <= 1'b0;
            cnt_wr_en              <= 1'b0;
            sel_reg_in_alu_decoder <= SEL_DECODER;
            out_valid              <= 1'b0;
            illegal_op             <= 1'b0;
            state                  <= RUN;
        end else if (!stall) begin
            // Bubbles and squashed slots both issue an all-zero NOP.
            opcode_q               <= '0;
            param_q                <= '0;
            literal_adr            <= '0;
            rd_sel1                <= '0;
            rd_sel2                <= '0;
            wr_sel                 <= '0;
            rd_en1                 <= 1'b0;
            rd_en2                 <= 1'b0;
            wr_en                  <= 1'b0;
            cnt_wr_en              <= 1'b0;
            sel_reg_in_alu_decoder <= SEL_DECODER;
            out_valid              <= 1'b0;
            illegal_op             <= 1'b0;
            if (instr_valid) begin
                if (state == SKIP) begin
                    state <= RUN;
                end else begin
                    opcode_q               <= d_opcode;
                    param_q                <= d_lit;
                    literal_adr            <= DATA_WIDTH'(d_lit);
                    rd_sel1                <= d_rd_sel1;
                    rd_sel2                <= d_rd_sel2;
                    wr_sel                 <= d_wr_sel;
                    rd_en1                 <= d_rd_en1;
                    rd_en2                 <= d_rd_en2;
                    wr_en                  <= d_wr_en;
                    cnt_wr_en              <= d_cnt_wr_en;
                    sel_reg_in_alu_decoder <= d_sel_alu;
                    out_valid              <= 1'b1;
                    illegal_op             <= d_illegal;
                    if (d_is_if && !d_cond_true) begin
                        state <= SKIP;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
// Inputs change 1ns after posedge; outputs sampled at the same point.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic        stall;
    logic [2:0]  status;
    logic [4:0]  opcode_q;
    logic [7:0]  param_q;
    logic [7:0]  literal_adr;
    logic [1:0]  rd_sel1;
    logic [1:0]  rd_sel2;
    logic [1:0]  wr_sel;
    logic        rd_en1;
    logic        rd_en2;
    logic        wr_en;
    logic        cnt_wr_en;
    logic        sel_reg_in_alu_decoder;
    logic        out_valid;
    logic        skip_pending;
    logic        illegal_op;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk                   (clk),
        .reset                 (reset),
        .instr                 (instr),
        .instr_valid           (instr_valid),
        .stall                 (stall),
        .status                (status),
        .opcode_q              (opcode_q),
        .param_q               (param_q),
        .literal_adr           (literal_adr),
        .rd_sel1               (rd_sel1),
        .rd_sel2               (rd_sel2),
        .wr_sel                (wr_sel),
        .rd_en1                (rd_en1),
        .rd_en2                (rd_en2),
        .wr_en                 (wr_en),
        .cnt_wr_en             (cnt_wr_en),
        .sel_reg_in_alu_decoder(sel_reg_in_alu_decoder),
        .out_valid             (out_valid),
        .skip_pending          (skip_pending),
        .illegal_op            (illegal_op)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {opcode, 0, op1, low8}; op2 lives at low8[4:3]
    function automatic logic [15:0] ins(input logic [4:0] op,
                                        input logic [1:0] op1,
                                        input logic [7:0] low8);
        return {op, 1'b0, op1, low8};
    endfunction

    task automatic cyc(input logic        v,
                       input logic        s,
                       input logic [15:0] w,
                       input logic [2:0]  st);
        instr_valid = v;
        stall       = s;
        instr       = w;
        status      = st;
        @(posedge clk);
        #1;
    endtask

    task automatic en_chk(input string tag, input logic [3:0] exp);
        chk(tag, {rd_en1, rd_en2, wr_en, cnt_wr_en}, exp);
    endtask

    initial begin
        reset = 1'b1;
        cyc(1'b0, 1'b0, 16'h0, 3'b000);
        cyc(1'b1, 1'b1, 16'hFFFF, 3'b111);
        chk("rst_en", {rd_en1, rd_en2, wr_en, cnt_wr_en}, 0);
        chk("rst_sel", {rd_sel1, rd_sel2, wr_sel}, 0);
        chk("rst_misc", {opcode_q, param_q, literal_adr}, 0);
        chk("rst_flags", {out_valid, illegal_op, skip_pending,
                          sel_reg_in_alu_decoder}, 0);
        reset = 1'b0;

        // VAL r2,0x5A
        cyc(1'b1, 1'b0, ins(5'd9, 2'd2, 8'h5A), 3'b000);
        en_chk("val_en", 4'b0010);
        chk("val_wsel", wr_sel, 2);
        chk("val_lit", literal_adr, 8'h5A);
        chk("val_src", sel_reg_in_alu_decoder, 0);
        chk("val_ov", out_valid, 1);
        chk("val_opc", opcode_q, 9);

        // ADD r1,r3
        cyc(1'b1, 1'b0, ins(5'd1, 2'd1, 8'h18), 3'b000);
        en_chk("add_en", 4'b1110);
        chk("add_sel", {rd_sel1, rd_sel2, wr_sel}, {2'd1, 2'd3, 2'd1});
        chk("add_src", sel_reg_in_alu_decoder, 1);

        // IFZ false -> ADD squashed -> SUB issues
        cyc(1'b1, 1'b0, ins(5'd12, 2'd0, 8'h00), 3'b000);
        en_chk("ifz_en", 4'b0000);
        chk("ifz_skip", skip_pending, 1);
        chk("ifz_ov", out_valid, 1);
        cyc(1'b1, 1'b0, ins(5'd1, 2'd1, 8'h18), 3'b000);
        chk("sq_add_wen", wr_en, 0);
        chk("sq_add_ov", out_valid, 0);
        chk("sq_add_skip", skip_pending, 0);
        cyc(1'b1, 1'b0, ins(5'd2, 2'd0, 8'h08), 3'b000);
        en_chk("sub_en", 4'b1110);
        chk("sub_sel", {rd_sel1, rd_sel2, wr_sel}, {2'd0, 2'd1, 2'd0});
        chk("sub_ov", out_valid, 1);

        // IFGT true -> GOTO 0x20
        cyc(1'b1, 1'b0, ins(5'd16, 2'd0, 8'h00), 3'b100);
        chk("ifgt_skip", skip_pending, 0);
        cyc(1'b1, 1'b0, ins(5'd11, 2'd0, 8'h20), 3'b000);
        en_chk("goto_en", 4'b0001);
        chk("goto_lit", literal_adr, 8'h20);

        // IFNZ false, bubbles and stalls keep the skip
        cyc(1'b1, 1'b0, ins(5'd13, 2'd0, 8'h00), 3'b001);
        chk("ifnz_skip", skip_pending, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, ins(5'd5, 2'd2, 8'h08), 3'b000);
            chk("bub_skip", skip_pending, 1);
            chk("bub_ov", out_valid, 0);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b1, ins(5'd5, 2'd2, 8'h08), 3'b000);
            chk("stl_skip", skip_pending, 1);
            chk("stl_wen", wr_en, 0);
        end
        cyc(1'b1, 1'b0, ins(5'd5, 2'd2, 8'h08), 3'b000);
        chk("sq_xor_wen", wr_en, 0);
        chk("sq_xor_ov", out_valid, 0);
        chk("sq_xor_skip", skip_pending, 0);

        // XOR r2,r1 issued, then held through a stall
        cyc(1'b1, 1'b0, ins(5'd5, 2'd2, 8'h08), 3'b000);
        en_chk("xor_en", 4'b1110);
        cyc(1'b1, 1'b1, ins(5'd11, 2'd3, 8'hFF), 3'b000);
        en_chk("hold_en", 4'b1110);
        chk("hold_sel", {rd_sel1, rd_sel2, wr_sel}, {2'd2, 2'd1, 2'd2});
        chk("hold_opc", opcode_q, 5);

        // Reset clears pending skip
        cyc(1'b1, 1'b0, ins(5'd14, 2'd0, 8'h00), 3'b000);
        chk("ifeq_skip", skip_pending, 1);
        reset = 1'b1;
        cyc(1'b1, 1'b1, ins(5'd3, 2'd1, 8'h10), 3'b000);
        reset = 1'b0;
        chk("rst2_skip", skip_pending, 0);
        chk("rst2_ov", out_valid, 0);
        cyc(1'b1, 1'b0, ins(5'd3, 2'd1, 8'h10), 3'b000);
        en_chk("and_en", 4'b1110);
        chk("and_sel", {rd_sel1, rd_sel2, wr_sel}, {2'd1, 2'd2, 2'd1});

        // Reserved opcode 0_1010 then NOP
        cyc(1'b1, 1'b0, ins(5'd10, 2'd3, 8'hFF), 3'b111);
        chk("ill_pulse", illegal_op, 1);
        en_chk("ill_en", 4'b0000);
        chk("ill_sel", {rd_sel1, rd_sel2, wr_sel}, 0);
        cyc(1'b1, 1'b0, ins(5'd0, 2'd0, 8'h00), 3'b000);
        chk("ill_drop", illegal_op, 0);
        chk("nop_ov", out_valid, 1);
        cyc(1'b1, 1'b0, ins(5'd31, 2'd1, 8'h00), 3'b000);
        chk("ill31", illegal_op, 1);

        // SHL r3, 3
        cyc(1'b1, 1'b0, ins(5'd7, 2'd3, 8'h03), 3'b000);
        en_chk("shl_en", 4'b1010);
        chk("shl_sel", {rd_sel1, wr_sel}, {2'd3, 2'd3});
        chk("shl_par", param_q, 3);
        chk("shl_ill", illegal_op, 0);

        // NOT r1,r2
        cyc(1'b1, 1'b0, ins(5'd6, 2'd1, 8'h10), 3'b000);
        en_chk("not_en", 4'b0110);
        chk("not_sel", {rd_sel1, rd_sel2, wr_sel}, {2'd0, 2'd2, 2'd1});

        // IFST true; then skipped IF does not chain
        cyc(1'b1, 1'b0, ins(5'd15, 2'd0, 8'h00), 3'b010);
        chk("ifst_skip", skip_pending, 0);
        cyc(1'b1, 1'b0, ins(5'd12, 2'd0, 8'h00), 3'b000);
        chk("ifz2_skip", skip_pending, 1);
        cyc(1'b1, 1'b0, ins(5'd12, 2'd0, 8'h00), 3'b000);
        chk("nochain", skip_pending, 0);
        chk("nochain_ov", out_valid, 0);
        cyc(1'b1, 1'b0, ins(5'd4, 2'd2, 8'h18), 3'b000);
        en_chk("or_en", 4'b1110);
        chk("or_ov", out_valid, 1);

        // Bubble issues NOP
        cyc(1'b0, 1'b0, ins(5'd4, 2'd2, 8'h18), 3'b000);
        en_chk("bub_en", 4'b0000);
        chk("bub_ov2", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
